// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg
//   Shared constants for the edge detector slice: the default values of the
//   two structural parameters, so the top and the synchronizer agree on them.
//   No ports (package).
package edge_detector_pkg;

  // Default number of independent input bits.
  localparam int unsigned DEF_WIDTH       = 1;
  // Default synchronizer depth; 0 means the input is already synchronous.
  localparam int unsigned DEF_SYNC_STAGES = 0;

endpackage : edge_detector_pkg

// File: rtl/edge_detector_sync_chain.sv
// sync_chain
//   N-deep shift register with synchronous active-low clear, used to bring an
//   asynchronous level into the i_clk domain. With SYNC_STAGES = 0 it is a
//   plain wire and adds no latency.
// Ports:
//   i_clk   in   1      clock, rising edge
//   i_rstn  in   1      synchronous active-low clear of every stage
//   i_d     in   WIDTH  raw input
//   o_q     out  WIDTH  input delayed by SYNC_STAGES clocks
module sync_chain
  import edge_detector_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  localparam int N = int'(SYNC_STAGES);

  if (N == 0) begin : g_pass
    assign o_q = i_d;
    // Clock and reset have no load in the pass-through build.
    logic w_unused_ctrl;
    assign w_unused_ctrl = i_clk & i_rstn;
  end else begin : g_chain
    logic [WIDTH-1:0] r_stage [N];

    always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
        for (int k = 0; k < N; k++) begin
          r_stage[k] <= '0;
        end
      end else begin
        r_stage[0] <= i_d;
        for (int k = 1; k < N; k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end

    assign o_q = r_stage[N-1];
  end

endmodule : sync_chain

// File: rtl/edge_detector.sv
// edge_detector
//   Per-bit synchronous edge detector. Each bit of i_din passes through an
//   optional synchronizer, then a current-sample and a previous-sample flop.
//   Rising/falling strobes are decoded from those two flops only, so they are
//   glitch-free and last exactly one clock per sampled transition.
// Ports:
//   i_clk     in   1      clock, rising edge
//   i_rstn    in   1      synchronous active-low reset (clears all history)
//   i_din     in   WIDTH  level input to monitor
//   o_r_edge  out  WIDTH  one-clock pulse per 0->1 transition of each bit
//   o_f_edge  out  WIDTH  one-clock pulse per 1->0 transition of each bit
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_r_edge,
  output logic [WIDTH-1:0] o_f_edge
);

  logic [WIDTH-1:0] w_din_sync;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_prev;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (w_din_sync_src()),
    .o_q    (w_din_sync)
  );

  // History clears to 0 on reset, so an input already high at release is
  // reported as one rising edge, and the clear itself produces no pulse
  // (both flops drop together).
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cur  <= '0;
      r_prev <= '0;
    end else begin
      r_cur  <= w_din_sync;
      r_prev <= r_cur;
    end
  end

  assign o_r_edge = r_cur & ~r_prev;
  assign o_f_edge = ~r_cur & r_prev;

  function automatic logic [WIDTH-1:0] w_din_sync_src();
    return i_din;
  endfunction

endmodule : edge_detector

// File: tb/tb_edge_detector.sv
// tb_edge_detector
//   Drives two detectors from one clock: WIDTH=1/SYNC_STAGES=0 and
//   WIDTH=4/SYNC_STAGES=2. Directed phases follow the test plan, then
//   randomized levels with occasional resets.
module tb_edge_detector;

  localparam int MAXC = 2048;
  localparam int S4   = 2;

  logic       clk;
  logic       rstn;
  logic       din1;
  logic [3:0] din4;
  logic       r1, f1;
  logic [3:0] r4, f4;

  edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) u_dut1 (
    .i_clk (clk), .i_rstn (rstn), .i_din (din1),
    .o_r_edge (r1), .o_f_edge (f1)
  );

  edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
    .i_clk (clk), .i_rstn (rstn), .i_din (din4),
    .o_r_edge (r4), .o_f_edge (f4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #4 clk = ~clk;

  // ---------------- reference model ----------------
  // History of what each edge sampled. The level seen by the detector after
  // edge n is the input sampled S edges earlier, unless a reset occurred at
  // any edge in that window (then it is 0). A pulse is the difference
  // between the level after edge n and after edge n-1 (0 if reset at n).
  logic       h_din1 [MAXC];
  logic [3:0] h_din4 [MAXC];
  bit         h_rst  [MAXC];
  int         edge_n = 0;

  function automatic logic [3:0] level4(int n);
    if (n - S4 < 0) return 4'b0;
    for (int m = n - S4; m <= n; m++) if (h_rst[m]) return 4'b0;
    return h_din4[n - S4];
  endfunction

  function automatic logic level1(int n);
    if (n < 0 || h_rst[n]) return 1'b0;
    return h_din1[n];
  endfunction

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  bit stim_done = 0;

  always @(posedge clk) begin
    logic       c1, p1;
    logic [3:0] c4, p4;
    if (edge_n < MAXC) begin
      h_din1[edge_n] = din1;
      h_din4[edge_n] = din4;
      h_rst[edge_n]  = !rstn;
      c1 = level1(edge_n);
      p1 = (h_rst[edge_n] || edge_n == 0) ? 1'b0 : level1(edge_n - 1);
      c4 = level4(edge_n);
      p4 = (h_rst[edge_n] || edge_n == 0) ? 4'b0 : level4(edge_n - 1);
      exp_q.push_back({c1 & ~p1, ~c1 & p1, c4 & ~p4, ~c4 & p4});
      edge_n++;
    end
  end

  // Monitor: outputs are valid every cycle; compare 1 ns after each edge.
  always @(posedge clk) begin
    logic [9:0] exp_v, act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {r1, f1, r4, f4};
      n_total++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL edge_%0d: got r1=%b f1=%b r4=%b f4=%b, want r1=%b f1=%b r4=%b f4=%b",
                    edge_n - 1, act_v[9], act_v[8], act_v[7:4], act_v[3:0],
                    exp_v[9], exp_v[8], exp_v[7:4], exp_v[3:0]);
      n_total++;
      if (!((r1 & f1) === 1'b1) && ((r4 & f4) === 4'b0)) n_pass++;
      else $display("FAIL both_high: got r1&f1=%b r4&f4=%b, want 0 and 0000", r1 & f1, r4 & f4);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rs, input logic d1, input logic [3:0] d4, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rstn = rs;
      din1 = d1;
      din4 = d4;
    end
  endtask

  initial begin
    rstn = 1'b0;
    din1 = 1'b0;
    din4 = 4'b0;
    step(0, 0, 4'b0000, 2);
    step(0, 1, 4'b0000, 4);   // input high while in reset
    step(1, 1, 4'b0000, 6);   // release: one rising pulse, then quiet
    step(1, 0, 4'b0000, 6);   // falling edge
    step(1, 0, 4'b0000, 10);  // long low
    step(1, 1, 4'b0000, 7);   // rising, held high
    for (int i = 0; i < 6; i++) step(1, i[0], 4'b0000, 1);  // toggle each clock
    step(1, 0, 4'b0000, 1);
    step(1, 1, 4'b0000, 1);
    step(0, 0, 4'b0000, 1);   // reset mid-toggle
    step(0, 1, 4'b0000, 2);
    step(1, 0, 4'b0000, 4);
    step(1, 0, 4'b0101, 5);   // 4-bit step, 2-cycle extra latency
    step(1, 0, 4'b0011, 5);   // simultaneous rise on bit1, fall on bit2
    step(1, 0, 4'b1111, 3);
    step(1, 0, 4'b0000, 3);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) != 0), $urandom_range(0, 1),
           4'($urandom_range(0, 15)), $urandom_range(1, 3));
    end
    step(1, 0, 4'b0000, 4);
    stim_done = 1;
    @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time bound in case the clock stops advancing stimulus.
  initial begin
    #200000;
    $display("FAIL timeout: got stim_done=%0d, want 1", stim_done);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $finish;
  end

endmodule : tb_edge_detector
